iter_divider: RTL and testbench
===============================

# iter_divider

Parametrised iterative radix-2 divider for the execute stage; the successor to the fixed 32-bit divider. It takes the forwarded rj/rkd operands on `en` and returns quotient and remainder with a registered `done`. `done` holds until the pipeline is no longer stalled. Generalisations: operand width is a parameter; zero-divisor and short-dividend cases resolve early; a `busy` status output is provided; flush aborts at any point.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- is_flush  in  1  synchronous abort; highest priority after reset.
- is_stall  in  1  downstream stall; holds `done`/results.
- en  in  1  start request, sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- dividend  in  WIDTH  rj operand.
- divisor  in  WIDTH  rkd operand.
- quotient  out  WIDTH  result, valid while `done`.
- remainder  out  WIDTH  result, valid while `done`.
- done  out  1  result valid.
- busy  out  1  high in PREP/CALC/FIX.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE, en=1:
  - latch operands, `is_signed`, and sign bits;
  - form magnitudes |dividend| and |divisor|;
  - go to PREP.
- PREP:
  - divisor==0 → quotient = all ones, remainder = dividend (unmodified), go to DONE;
  - else load partial remainder = 0, shift register = |dividend|, counter = WIDTH, go to CALC.
- CALC, each cycle:
  - partial remainder = {rem, msb of shift register} − |divisor| when non-negative, else the shifted value;
  - quotient bit shifts into the shift register LSB;
  - counter decrements; counter reaches 0 → FIX.
- FIX:
  - quotient negated when signed and operand signs differ; remainder takes the dividend's sign (truncation toward zero);
  - go to DONE.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0. This falls out of the magnitude path; there is no special case.
- DONE:
  - `done`=1;
  - is_stall=1 stays in DONE with outputs frozen;
  - is_stall=0 goes to IDLE on the next edge.
- `en` is ignored outside IDLE. Operands may change freely after the start cycle.
- is_flush=1 in any state: next state IDLE, `done`=0, `busy`=0; `en` on the flush cycle is ignored.
- Reset: state IDLE; quotient, remainder, done, busy all 0.

## Timing
- Cycle 0 is the cycle in which `en` is sampled high in IDLE.
- Normal path: `done`=1 from cycle WIDTH+3 (cycle 35 for WIDTH=32).
- Zero divisor: `done`=1 from cycle 2.
- `done` lasts 1 cycle plus one cycle per stalled cycle.
- Back-to-back: a new `en` is accepted in the first IDLE cycle after DONE, so there is at least one idle cycle between results.
- Flush and DONE exit on the same edge: result is IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - PREP computes lz = leading zeros of |dividend|;
  - shift register preloaded with |dividend| << lz; counter = WIDTH − lz;
  - |dividend| < |divisor| (including dividend 0): PREP skips CALC and goes directly to DONE with quotient = 0, remainder = dividend; `done` from cycle 2;
  - otherwise `done` from cycle (WIDTH−lz)+3.
- DIV_EARLY_OUT_EN undefined: fixed WIDTH-iteration latency; only the zero-divisor fast path remains.

## Test plan
- WIDTH=32, unsigned 100/7, macro off → quotient=14, remainder=2, `done` rises cycle 35, busy high cycles 1–34.
- Signed 0xFFFFFFF9 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- Divisor 0, dividend 0x12345678 → quotient=0xFFFFFFFF, remainder=0x12345678, `done` cycle 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Flush and stall:
  - is_flush at cycle 10 of 100/7 → `done` never rises, busy=0 cycle 11; fresh en at cycle 12 yields 14/2 at cycle 47;
  - is_stall high 3 cycles over `done` → `done` held 4 cycles, results stable.
- Macro on:
  - unsigned 5/7 → quotient=0, remainder=5, `done` cycle 2;
  - unsigned 100/7 (lz=25) → `done` cycle 10, quotient=14, remainder=2.

Source files
------------

// File: rtl/iter_divider.sv
// Iterative radix-2 signed/unsigned divider with registered quotient/remainder and done/busy.
// Optional DIV_EARLY_OUT_EN: skip leading-zero iterations and short-circuit |dividend| < |divisor|.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_flush,
  input  logic             is_stall,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StCalc = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_abs_q, dvs_abs_q;
  logic [WIDTH-1:0] rem_q, sh_q, quo_q, res_rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q;
  logic             done_q, busy_q;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   shifted;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic             early;
  logic [WIDTH-1:0] sh_init;
  logic [CNT_W-1:0] cnt_init;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // Partial remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
  assign shifted = {rem_q, sh_q[WIDTH-1]};
  assign q_bit   = shifted >= {1'b0, dvs_abs_q};
  assign rem_nx  = q_bit ? (shifted[WIDTH-1:0] - dvs_abs_q) : shifted[WIDTH-1:0];

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  logic             lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (dvd_abs_q[i]) lz_found = 1'b1;
        else              lz = lz + CNT_W'(1);
      end
    end
  end

  assign early    = dvd_abs_q < dvs_abs_q;
  assign sh_init  = dvd_abs_q << lz;
  assign cnt_init = CNT_W'(WIDTH) - lz;
`else
  assign early    = 1'b0;
  assign sh_init  = dvd_abs_q;
  assign cnt_init = CNT_W'(WIDTH);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (en) state_d = StPrep;
      StPrep: begin
        if (dvs_abs_q == '0 || early) state_d = StDone;
        else                          state_d = StCalc;
      end
      StCalc: if (cnt_q == CNT_W'(1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (!is_stall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (is_flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dvd_abs_q <= '0;
      dvs_abs_q <= '0;
      rem_q     <= '0;
      sh_q      <= '0;
      quo_q     <= '0;
      res_rem_q <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == StDone);
      busy_q  <= (state_d == StPrep) || (state_d == StCalc) || (state_d == StFix);
      case (state_q)
        StIdle: begin
          if (en) begin
            dvd_q     <= dividend;
            dvd_abs_q <= dvd_neg ? -dividend : dividend;
            dvs_abs_q <= dvs_neg ? -divisor : divisor;
            q_neg_q   <= dvd_neg ^ dvs_neg;
            r_neg_q   <= dvd_neg;
          end
        end
        StPrep: begin
          if (dvs_abs_q == '0) begin
            quo_q     <= '1;
            res_rem_q <= dvd_q;
          end else if (early) begin
            quo_q     <= '0;
            res_rem_q <= dvd_q;
          end else begin
            rem_q <= '0;
            sh_q  <= sh_init;
            cnt_q <= cnt_init;
          end
        end
        StCalc: begin
          rem_q <= rem_nx;
          sh_q  <= {sh_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        StFix: begin
          quo_q     <= q_neg_q ? -sh_q : sh_q;
          res_rem_q <= r_neg_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = res_rem_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (WIDTH=32); latency expectations follow DIV_EARLY_OUT_EN.
module tb_iter_divider;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_flush = 1'b0;
  logic        is_stall = 1'b0;
  logic        en = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .is_flush (is_flush),
    .is_stall (is_stall),
    .en       (en),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done),
    .busy     (busy)
  );

  // Starts one operation and returns at the negedge of the first done cycle (lat = cycle index).
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output int busy_bad);
    bit seen;
    seen = 1'b0;
    busy_bad = 0;
    @(negedge clk);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    en        = 1'b1;
    @(posedge clk);
    lat = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      en       = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      @(posedge clk);
      lat++;
    end
    if (!seen) lat = -1;
    if (busy) busy_bad++;
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests += 4;
    if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", quotient); end
    if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", remainder); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic        sg[10];
    logic [31:0] a[10], b[10], eq[10], er[10];
    int          el[10];
    int          lat, bb;
    logic [31:0] q, r;
    sg[0] = 0; a[0] = 32'd100;        b[0] = 32'd7;          eq[0] = 32'd14;
    er[0] = 32'd2;          el[0] = EARLY ? 10 : 35;
    sg[1] = 1; a[1] = 32'hFFFF_FFF9;  b[1] = 32'd2;          eq[1] = 32'hFFFF_FFFD;
    er[1] = 32'hFFFF_FFFF;  el[1] = EARLY ? 6 : 35;
    sg[2] = 1; a[2] = 32'd7;          b[2] = 32'hFFFF_FFFE;  eq[2] = 32'hFFFF_FFFD;
    er[2] = 32'd1;          el[2] = EARLY ? 6 : 35;
    sg[3] = 1; a[3] = 32'hFFFF_FFF9;  b[3] = 32'hFFFF_FFFE;  eq[3] = 32'd3;
    er[3] = 32'hFFFF_FFFF;  el[3] = EARLY ? 6 : 35;
    sg[4] = 0; a[4] = 32'h1234_5678;  b[4] = 32'd0;          eq[4] = 32'hFFFF_FFFF;
    er[4] = 32'h1234_5678;  el[4] = 2;
    sg[5] = 1; a[5] = 32'h8000_0000;  b[5] = 32'hFFFF_FFFF;  eq[5] = 32'h8000_0000;
    er[5] = 32'd0;          el[5] = 35;
    sg[6] = 0; a[6] = 32'hFFFF_FFFF;  b[6] = 32'h10;         eq[6] = 32'h0FFF_FFFF;
    er[6] = 32'hF;          el[6] = 35;
    sg[7] = 0; a[7] = 32'd5;          b[7] = 32'd7;          eq[7] = 32'd0;
    er[7] = 32'd5;          el[7] = EARLY ? 2 : 35;
    sg[8] = 1; a[8] = 32'hFFFF_FFFB;  b[8] = 32'd7;          eq[8] = 32'd0;
    er[8] = 32'hFFFF_FFFB;  el[8] = EARLY ? 2 : 35;
    sg[9] = 0; a[9] = 32'd0;          b[9] = 32'd5;          eq[9] = 32'd0;
    er[9] = 32'd0;          el[9] = EARLY ? 2 : 35;
    for (int i = 0; i < 10; i++) begin
      run_op(sg[i], a[i], b[i], lat, q, r, bb);
      n_tests += 4;
      if (q !== eq[i]) begin n_fail++; $display("FAIL vec%0d_q: got %h expected %h", i, q, eq[i]); end
      if (r !== er[i]) begin n_fail++; $display("FAIL vec%0d_r: got %h expected %h", i, r, er[i]); end
      if (lat !== el[i]) begin n_fail++; $display("FAIL vec%0d_lat: got %0d expected %0d", i, lat, el[i]); end
      if (bb !== 0) begin n_fail++; $display("FAIL vec%0d_busy: got %0d bad cycles expected 0", i, bb); end
    end
  endtask

  task automatic test_flush();
    int          cyc, lat, bb;
    bit          saw;
    logic [31:0] q, r;
    saw = 1'b0;
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd7;
    en        = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      en = 1'b0;
      if (done) saw = 1'b1;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    if (done) saw = 1'b1;
    is_flush = 1'b1;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    is_flush = 1'b0;
    en       = 1'b0;
    n_tests += 2;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_c11: got busy=%b done=%b expected 0 0", busy, done);
    end
    if (saw) begin n_fail++; $display("FAIL flush_done_early: got done=1 expected 0"); end
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, bb);
    n_tests += 3;
    if (q !== 32'd14 || r !== 32'd2) begin
      n_fail++;
      $display("FAIL flush_rerun: got %0d/%0d expected 14/2", q, r);
    end
    if (12 + lat !== (EARLY ? 22 : 47)) begin
      n_fail++;
      $display("FAIL flush_rerun_cycle: got %0d expected %0d", 12 + lat, EARLY ? 22 : 47);
    end
    if (bb !== 0) begin n_fail++; $display("FAIL flush_rerun_busy: got %0d expected 0", bb); end
  endtask

  task automatic test_flush_en();
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    en        = 1'b1;
    is_flush  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en       = 1'b0;
    is_flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_en_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stall();
    int          lat, bb, held;
    logic [31:0] q, r;
    bit          unstable;
    unstable = 1'b0;
    is_stall = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, bb);
    held = 1;
    for (int k = 0; k < 10; k++) begin
      if (held == 4) is_stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (!done) break;
      held++;
      if (quotient !== q || remainder !== r) unstable = 1'b1;
    end
    is_stall = 1'b0;
    n_tests += 3;
    if (held !== 4) begin n_fail++; $display("FAIL stall_hold: got %0d cycles expected 4", held); end
    if (unstable) begin n_fail++; $display("FAIL stall_stable: got changing results expected frozen"); end
    if (q !== 32'd14 || r !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_result: got %0d/%0d expected 14/2", q, r);
    end
  endtask

  task automatic test_flush_done();
    int          lat, bb;
    logic [31:0] q, r;
    is_stall = 1'b1;
    run_op(1'b0, 32'd0, 32'd0, lat, q, r, bb);
    is_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    is_flush = 1'b0;
    is_stall = 1'b0;
    n_tests += 2;
    if (lat !== 2) begin n_fail++; $display("FAIL flush_done_lat: got %0d expected 2", lat); end
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int          lat, bb;
    logic [31:0] q, r;
    bit          seen;
    seen = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, bb);
    is_signed = 1'b0;
    dividend  = 32'd200;
    divisor   = 32'd9;
    en        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got busy=%b expected 1", busy); end
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen || quotient !== 32'd22 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_result: got done=%b %0d/%0d expected 1 22/2", seen, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_flush();
    test_flush_en();
    test_stall();
    test_flush_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
